// File: rtl/aes_mc_pkg.sv
// Shared constants, FSM state type and GF(2^8) helpers for the (Inv)MixColumns unit.
// SMAESH_MC_INVERSE_EN enables the inverse matrix in the datapath.
package aes_mc_pkg;

  localparam int unsigned NumCols = 4;
  localparam int unsigned ColW    = 32;
  localparam int unsigned ByteW   = 8;

  // Coefficient i of the first matrix row sits at bits [8*i +: 8].
  localparam logic [31:0] FwdCoef = 32'h01010302;
  localparam logic [31:0] InvCoef = 32'h090d0b0e;

  typedef enum logic [1:0] {StIdle, StRun, StDone} mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant with only bits 0..3 set, from precomputed x, 2x, 4x, 8x terms.
  function automatic logic [7:0] gf_mul_terms(input logic [3:0] coef,
                                              input logic [3:0][7:0] t);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (coef[i]) p ^= t[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_mc_column_dual.sv
// Combinational single-column (Inv)MixColumns built on shared xtime chains.
// The inverse matrix exists only when SMAESH_MC_INVERSE_EN is defined.
module aes_mc_column_dual
  import aes_mc_pkg::*;
(
  input  logic [ColW-1:0] col_i,
  input  logic            inverse_i,
  output logic [ColW-1:0] col_o
);

  // terms[b][p] = 2^p * byte b
  logic [NumCols-1:0][3:0][ByteW-1:0] terms;
  logic [ColW-1:0] fwd_col;

  always_comb begin
    for (int b = 0; b < NumCols; b++) begin
      terms[b][0] = col_i[ByteW*b +: ByteW];
      terms[b][1] = xtime(terms[b][0]);
`ifdef SMAESH_MC_INVERSE_EN
      terms[b][2] = xtime(terms[b][1]);
      terms[b][3] = xtime(terms[b][2]);
`else
      terms[b][2] = '0;
      terms[b][3] = '0;
`endif
    end
  end

  always_comb begin
    fwd_col = '0;
    for (int r = 0; r < NumCols; r++) begin
      for (int k = 0; k < NumCols; k++) begin
        fwd_col[ByteW*r +: ByteW] ^= gf_mul_terms(FwdCoef[ByteW*((k - r + 4) % 4) +: 4], terms[k]);
      end
    end
  end

`ifdef SMAESH_MC_INVERSE_EN
  logic [ColW-1:0] inv_col;

  always_comb begin
    inv_col = '0;
    for (int r = 0; r < NumCols; r++) begin
      for (int k = 0; k < NumCols; k++) begin
        inv_col[ByteW*r +: ByteW] ^= gf_mul_terms(InvCoef[ByteW*((k - r + 4) % 4) +: 4], terms[k]);
      end
    end
  end

  assign col_o = inverse_i ? inv_col : fwd_col;
`else
  logic unused_inverse;
  assign unused_inverse = inverse_i;
  assign col_o = fwd_col;
`endif

endmodule

// File: rtl/aes_mc_multi_column.sv
// Multi-cycle share-parallel (Inv)MixColumns: NCPC columns per cycle, transformed in place.
// SMAESH_MC_INVERSE_EN enables per-transaction inverse mode via in_inverse.
module aes_mc_multi_column
  import aes_mc_pkg::*;
#(
  parameter int unsigned D    = 2,
  parameter int unsigned NCPC = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_inverse,
  input  logic [NumCols*ColW*D-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NumCols*ColW*D-1:0] out_data,
  output logic                      busy
);

  localparam int unsigned BlockW = NumCols * ColW;
  localparam int unsigned StateW = BlockW * D;
  localparam int unsigned Steps  = NumCols / NCPC;
  localparam int unsigned CntW   = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  if (!(NCPC == 1 || NCPC == 2 || NCPC == 4)) begin : gen_ncpc_check
    $error("aes_mc_multi_column: NCPC must be 1, 2 or 4");
  end
  if (D < 1) begin : gen_d_check
    $error("aes_mc_multi_column: D must be at least 1");
  end

  mc_state_e       st_q, st_d;
  logic [StateW-1:0] state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load;
  logic            inv_sel;

  logic [ColW-1:0] col_in  [D][NCPC];
  logic [ColW-1:0] col_out [D][NCPC];

`ifdef SMAESH_MC_INVERSE_EN
  logic mode_q, mode_d;
  assign inv_sel = mode_q;
`else
  logic unused_in_inverse;
  assign unused_in_inverse = in_inverse;
  assign inv_sel = 1'b0;
`endif

  always_comb begin
    for (int s = 0; s < int'(D); s++) begin
      for (int j = 0; j < int'(NCPC); j++) begin
        col_in[s][j] = state_q[s*BlockW + (int'(cnt_q)*NCPC + j)*ColW +: ColW];
      end
    end
  end

  for (genvar s = 0; s < int'(D); s++) begin : gen_share
    for (genvar j = 0; j < int'(NCPC); j++) begin : gen_col
      aes_mc_column_dual u_col (
        .col_i     (col_in[s][j]),
        .inverse_i (inv_sel),
        .col_o     (col_out[s][j])
      );
    end
  end

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
`ifdef SMAESH_MC_INVERSE_EN
    mode_d  = mode_q;
`endif
    unique case (st_q)
      StIdle: load = in_valid;
      StRun: begin
        for (int s = 0; s < int'(D); s++) begin
          for (int j = 0; j < int'(NCPC); j++) begin
            state_d[s*BlockW + (int'(cnt_q)*NCPC + j)*ColW +: ColW] = col_out[s][j];
          end
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) st_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          if (in_valid) load = 1'b1;
          else          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
    // A load overrides everything: fresh state, counter restart, mode latched.
    if (load) begin
      state_d = in_data;
      cnt_d   = '0;
      st_d    = StRun;
`ifdef SMAESH_MC_INVERSE_EN
      mode_d  = in_inverse;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      state_q <= '0;
      cnt_q   <= '0;
`ifdef SMAESH_MC_INVERSE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef SMAESH_MC_INVERSE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign in_ready  = (st_q == StIdle) | ((st_q == StDone) & out_ready);
  assign out_valid = (st_q == StDone);
  assign busy      = (st_q != StIdle);
  assign out_data  = state_q;

endmodule

// File: tb/tb_aes_mc_multi_column.sv
// Self-checking bench: three instances (NCPC = 1, 4, 2; D = 2) against a GF(2^8) matrix model.
// Inverse expectations follow SMAESH_MC_INVERSE_EN.
module tb_aes_mc_multi_column;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid [3];
  logic         in_inverse [3];
  logic         out_ready [3];
  logic         in_ready [3];
  logic         out_valid [3];
  logic         busy [3];
  logic [255:0] in_data [3];
  logic [255:0] out_data [3];

  int checks = 0;
  int failures = 0;
  logic [127:0] exp0[$];
  logic [127:0] exp1[$];
  logic [127:0] exp2[$];

  aes_mc_multi_column #(.D(2), .NCPC(1)) u_dut_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_inverse(in_inverse[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
  );
  aes_mc_multi_column #(.D(2), .NCPC(4)) u_dut_n4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_inverse(in_inverse[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );
  aes_mc_multi_column #(.D(2), .NCPC(2)) u_dut_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_inverse(in_inverse[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2])
  );

  // ---------------- model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic inv);
    logic [7:0] cf [4];
    logic [31:0] o = '0;
    if (inv) begin cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09; end
    else     begin cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01; end
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        o[8*r +: 8] ^= gmul(cf[(k - r + 4) % 4], c[8*k +: 8]);
    return o;
  endfunction

  function automatic logic eff_inv(input logic inv);
`ifdef SMAESH_MC_INVERSE_EN
    return inv;
`else
    return 1'b0 & inv;
`endif
  endfunction

  function automatic logic [127:0] mc_state(input logic [127:0] x, input logic inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[32*c +: 32] = mix_col(x[32*c +: 32], eff_inv(inv));
    return o;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n && out_valid[i] && out_ready[i]) begin
        logic [127:0] e;
        logic have;
        have = 1'b0;
        e = '0;
        case (i)
          0: if (exp0.size() > 0) begin e = exp0.pop_front(); have = 1'b1; end
          1: if (exp1.size() > 0) begin e = exp1.pop_front(); have = 1'b1; end
          default: if (exp2.size() > 0) begin e = exp2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output dut%0d actual=%h required=none", i, out_data[i]);
        end else begin
          check($sformatf("result_dut%0d", i),
                {128'h0, out_data[i][127:0] ^ out_data[i][255:128]}, {128'h0, e});
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge + #1) ----------------
  task automatic send(input int i, input logic [127:0] x, input logic [127:0] r, input logic inv);
    int n = 0;
    in_valid[i] = 1'b1;
    in_data[i] = {r, x ^ r};
    in_inverse[i] = inv;
    while (!in_ready[i] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready[i]) begin
      check($sformatf("send_timeout_dut%0d", i), 256'(n), 256'(0));
      in_valid[i] = 1'b0;
      return;
    end
    case (i)
      0: exp0.push_back(mc_state(x, inv));
      1: exp1.push_back(mc_state(x, inv));
      default: exp2.push_back(mc_state(x, inv));
    endcase
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid[i] && n < 30);
  endtask

  logic [127:0] x, r, snap_x;
  logic [255:0] snap;
  int n;

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_inverse[i] = 1'b0; out_ready[i] = 1'b1; in_data[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_in_ready_%0d", i), 256'(in_ready[i]), 256'(1));
      check($sformatf("reset_out_valid_%0d", i), 256'(out_valid[i]), 256'(0));
      check($sformatf("reset_busy_%0d", i), 256'(busy[i]), 256'(0));
      check($sformatf("reset_out_data_%0d", i), out_data[i], 256'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model with known MixColumns vectors.
    check("model_fwd_db", 256'(mix_col(32'h455313db, 1'b0)), 256'(32'hbca14d8e));
    check("model_inv_8e", 256'(mix_col(32'hbca14d8e, 1'b1)), 256'(32'h455313db));
    check("model_fwd_d4", 256'(mix_col(32'hd5d4d4d4, 1'b0)), 256'(32'hd6d7d5d5));
    check("model_fwd_01", 256'(mix_col(32'h01010101, 1'b0)), 256'(32'h01010101));

    // NCPC=1 forward; in_valid held during RUN must be ignored.
    x = {32'h01010101, 32'h01010101, 32'h01010101, 32'h455313db};
    send(0, x, 128'h0, 1'b0);
    in_valid[0] = 1'b1; in_data[0] = {256{1'b1}};
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    wait_valid(0, n);
    check("latency_ncpc1", 256'(n + 1), 256'(4));
    check("literal_ncpc1", out_data[0],
          {128'h0, 32'h01010101, 32'h01010101, 32'h01010101, 32'hbca14d8e});

    // NCPC=4 inverse.
    send(1, {4{32'hbca14d8e}}, 128'h0, 1'b1);
    wait_valid(1, n);
    check("latency_ncpc4", 256'(n), 256'(1));
`ifdef SMAESH_MC_INVERSE_EN
    check("literal_inv", out_data[1], {128'h0, {4{32'h455313db}}});
`else
    check("literal_inv_as_fwd", out_data[1], {128'h0, mc_state({4{32'hbca14d8e}}, 1'b0)});
`endif
    send(1, {4{32'hd5d4d4d4}}, 128'h0, 1'b0);
    wait_valid(1, n);
    check("literal_d4", out_data[1], {128'h0, {4{32'hd6d7d5d5}}});
    // in_inverse=1: forward result when the inverse datapath is absent.
    send(1, {4{32'h455313db}}, 128'h0, 1'b1);
    wait_valid(1, n);
`ifdef SMAESH_MC_INVERSE_EN
    check("inverse_sel", out_data[1], {128'h0, mc_state({4{32'h455313db}}, 1'b1)});
`else
    check("inverse_ignored", out_data[1], {128'h0, {4{32'hbca14d8e}}});
`endif

    // NCPC=2, masked random states, alternating modes, back-to-back.
    for (int k = 0; k < 100; k++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      r = {$urandom, $urandom, $urandom, $urandom};
      send(2, x, r, k[0]);
    end
    wait_valid(2, n);
    @(posedge clk); #1;

    // Backpressure on NCPC=2.
    out_ready[2] = 1'b0;
    send(2, 128'h00112233445566778899aabbccddeeff, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 1'b0);
    wait_valid(2, n);
    check("latency_ncpc2", 256'(n), 256'(2));
    snap = out_data[2];
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_data", out_data[2], snap);
      check("hold_in_ready", 256'(in_ready[2]), 256'(0));
    end
    snap_x = 128'hdeadbeef0123456789abcdeffedcba98;
    out_ready[2] = 1'b1;
    in_valid[2] = 1'b1;
    in_data[2] = {128'h0, snap_x};
    in_inverse[2] = 1'b0;
    exp2.push_back(mc_state(snap_x, 1'b0));
    #1;
    check("b2b_in_ready", 256'(in_ready[2]), 256'(1));
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    check("b2b_out_valid_low", 256'(out_valid[2]), 256'(0));
    check("b2b_busy", 256'(busy[2]), 256'(1));
    wait_valid(2, n);
    @(posedge clk); #1;

    // Reset during RUN on NCPC=1.
    send(0, {4{32'hd5d4d4d4}}, 128'h5, 1'b0);
    @(posedge clk); #1;
    check("mid_run_busy", 256'(busy[0]), 256'(1));
    rst_n = 1'b0;
    #1;
    exp0.delete();
    check("rst_out_valid", 256'(out_valid[0]), 256'(0));
    check("rst_in_ready", 256'(in_ready[0]), 256'(1));
    check("rst_out_data", out_data[0], 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, {32'h01020304, 32'hf0e0d0c0, 32'h455313db, 32'hd5d4d4d4}, 128'h77, 1'b1);
    wait_valid(0, n);
    @(posedge clk); #1;

    n = 0;
    while ((exp0.size() + exp1.size() + exp2.size()) != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check("queues_drained", 256'(exp0.size() + exp1.size() + exp2.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
